// File: rtl/btn_pkg.sv
// Shared defaults and counter-width helper for the button conditioner.
package btn_pkg;

  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 10000000;

  // Counter width for a count that runs 0..n-1; never narrower than one bit.
  function automatic int btn_cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef logic [btn_cnt_w(DEF_DEBOUNCE_CYCLES)-1:0] btn_cnt_t;

endpackage

// File: rtl/btn_debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, press/release pulses.
// Auto-repeat on a held press is built only when BTN_REPEAT_EN is defined.
module btn_debounce_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic reset_n,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int CNT_W = btn_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic             accept;

`ifdef BTN_REPEAT_EN
  localparam int REP_W = btn_cnt_w((REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD);
  localparam logic [REP_W-1:0] REP_FIRST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] REP_NEXT  = REP_W'(REPEAT_PERIOD - 1);

  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic             rep_per_q, rep_per_d;
`else
  localparam int unused_rep_cfg = REPEAT_DELAY + REPEAT_PERIOD;
`endif

  always_comb begin
    cnt_d     = '0;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    accept    = 1'b0;
    // Count only while the synchronized pin disagrees; any agreement restarts the window.
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        accept    = 1'b1;
        level_d   = sync2_q;
        press_d   = sync2_q;
        release_d = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
`ifdef BTN_REPEAT_EN
    rep_cnt_d = '0;
    rep_per_d = 1'b0;
    // A release accept on the same edge wins over a repeat pulse.
    if (level_q && !accept) begin
      rep_cnt_d = rep_cnt_q + 1'b1;
      rep_per_d = rep_per_q;
      if (rep_cnt_q == (rep_per_q ? REP_NEXT : REP_FIRST)) begin
        press_d   = 1'b1;
        rep_cnt_d = '0;
        rep_per_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
`ifdef BTN_REPEAT_EN
      rep_cnt_q <= '0;
      rep_per_q <= 1'b0;
`endif
    end else begin
      sync1_q   <= btn_in;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
`ifdef BTN_REPEAT_EN
      rep_cnt_q <= rep_cnt_d;
      rep_per_q <= rep_per_d;
`endif
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule

// File: rtl/button_conditioner.sv
// NUM_BTN independent debounced button channels with press/release pulses.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while a button is held.
module button_conditioner
  import btn_pkg::*;
#(
  parameter int NUM_BTN         = 4,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_BTN-1:0] btn_in,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release
);

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_in      (btn_in[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i])
    );
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner: a window-based reference model predicts
// level/press/release per clock edge; a negedge monitor compares the DUT against it.
module tb_button_conditioner;

  localparam int NB = 4;
  localparam int DC = 8;
  localparam int RD = 20;
  localparam int RP = 5;

  typedef struct packed {
    logic [NB-1:0] lvl;
    logic [NB-1:0] prs;
    logic [NB-1:0] rel;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [NB-1:0] btn_in = '0;
  logic [NB-1:0] btn_level, btn_press, btn_release;

  int   checks = 0;
  int   errors = 0;
  exp_t expq[$];

  // Reference model state: pin samples delayed by the synchronizer, the most
  // recent DC synchronized samples, and the accepted level per channel.
  bit pipe[NB][$];
  bit shist[NB][$];
  bit mlvl[NB];
`ifdef BTN_REPEAT_EN
  int held[NB];
`endif

  always #5 clk = ~clk;

  button_conditioner #(
    .NUM_BTN         (NB),
    .DEBOUNCE_CYCLES (DC),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .btn_in      (btn_in),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release)
  );

  task automatic chk(input string name, input logic [NB-1:0] act, input logic [NB-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NB; c++) begin
      pipe[c].delete();
      pipe[c].push_back(1'b0);
      pipe[c].push_back(1'b0);
      shist[c].delete();
      mlvl[c] = 1'b0;
`ifdef BTN_REPEAT_EN
      held[c] = 0;
`endif
    end
  endtask

  // A change is accepted when the last DC synchronized samples all differ from the level.
  task automatic model_edge(input logic [NB-1:0] pins, output exp_t e);
    e = '0;
    for (int c = 0; c < NB; c++) begin
      bit s;
      bit acc;
      pipe[c].push_back(pins[c]);
      s = pipe[c].pop_front();
      shist[c].push_back(s);
      if (shist[c].size() > DC) void'(shist[c].pop_front());
      acc = (shist[c].size() == DC);
      for (int k = 0; k < shist[c].size(); k++)
        if (shist[c][k] == mlvl[c]) acc = 1'b0;
      if (acc) begin
        mlvl[c]  = s;
        e.prs[c] = s;
        e.rel[c] = !s;
`ifdef BTN_REPEAT_EN
        held[c]  = 0;
`endif
      end
`ifdef BTN_REPEAT_EN
      else if (mlvl[c]) begin
        held[c]++;
        if (held[c] == RD || (held[c] > RD && (held[c] - RD) % RP == 0)) e.prs[c] = 1'b1;
      end
`endif
      e.lvl[c] = mlvl[c];
    end
  endtask

  task automatic tick(input logic [NB-1:0] pins);
    exp_t e;
    btn_in = pins;
    model_edge(pins, e);
    @(posedge clk);
    expq.push_back(e);
    #1;
  endtask

  task automatic reset_pulse(input int n);
    @(negedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async_rst_level", btn_level, '0);
    chk("async_rst_press", btn_press, '0);
    chk("async_rst_release", btn_release, '0);
    model_reset();
    repeat (n) begin
      @(posedge clk);
      expq.push_back('0);
      #1;
    end
    reset_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (expq.size() > 0) begin
      exp_t e;
      e = expq.pop_front();
      chk("level", btn_level, e.lvl);
      chk("press", btn_press, e.prs);
      chk("release", btn_release, e.rel);
      chk("press_and_release", btn_press & btn_release, '0);
    end
  end

  initial begin
    logic [NB-1:0] cur;
    int            hold[NB];
    cur = '0;
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_level", btn_level, '0);
    chk("reset_press", btn_press, '0);
    chk("reset_release", btn_release, '0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    repeat (5) tick(cur);

    // Clean press on channel 0, held long enough to exercise auto-repeat when built.
    cur[0] = 1'b1;
    repeat (60) tick(cur);
    cur[0] = 1'b0;
    repeat (15) tick(cur);

    // Bouncing channel 1: toggles every 3 cycles, never stable long enough.
    for (int i = 0; i < 40; i++) begin
      cur[1] = ((i / 3) % 2) == 0;
      tick(cur);
    end
    cur[1] = 1'b0;
    repeat (15) tick(cur);

    // Channels 2 and 3 press and release together.
    cur[3:2] = 2'b11;
    repeat (15) tick(cur);
    cur[3:2] = 2'b00;
    repeat (15) tick(cur);

    // Reset part-way through a press; pin stays high across the reset.
    cur[0] = 1'b1;
    repeat (6) tick(cur);
    reset_pulse(1);
    repeat (15) tick(cur);
    cur[0] = 1'b0;
    repeat (15) tick(cur);

    // Random holds per channel, mixing short glitches and accepted changes.
    for (int c = 0; c < NB; c++) hold[c] = $urandom_range(1, 14);
    for (int pass = 0; pass < 2; pass++) begin
      repeat (200) begin
        for (int c = 0; c < NB; c++) begin
          hold[c]--;
          if (hold[c] == 0) begin
            cur[c]  = ~cur[c];
            hold[c] = $urandom_range(1, 14);
          end
        end
        tick(cur);
      end
      if (pass == 0) reset_pulse($urandom_range(1, 3));
    end

    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (expq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0 pending entries", expq.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  NUM_BTN, 4, number of independent button channels.
  DEBOUNCE_CYCLES, 1000000, consecutive stable cycles needed to accept a change (10 ms at 100 MHz); SHALL be at least 2.
  REPEAT_DELAY, 50000000, held cycles before the first auto-repeat pulse; used only with BTN_REPEAT_EN.
  REPEAT_PERIOD, 10000000, cycles between later auto-repeat pulses; used only with BTN_REPEAT_EN.
REQ-002 Ports (name, direction, width, meaning), one per line; clock and reset first:
  clk, input, 1, single system clock; all state SHALL be on its rising edge.
  reset_n, input, 1, asynchronous active-low reset.
  btn_in, input, NUM_BTN, raw asynchronous button pins.
  btn_level, output, NUM_BTN, debounced registered level.
  btn_press, output, NUM_BTN, one-cycle pulse on an accepted 0->1 change (and on auto-repeat).
  btn_release, output, NUM_BTN, one-cycle pulse on an accepted 1->0 change.
REQ-003 All outputs SHALL be driven directly from flops, with no combinational path from btn_in.

Function
REQ-004 Each channel SHALL pass btn_in[i] through a 2-flop synchronizer; the second-stage value is "sync".
REQ-005 Each channel SHALL hold a stability counter of width $clog2(DEBOUNCE_CYCLES).
REQ-006 While sync equals btn_level[i], the counter SHALL be held at 0.
REQ-007 While sync differs from btn_level[i], the counter SHALL increment once per cycle.
REQ-008 If sync returns to equal btn_level[i] before the count completes, the counter SHALL clear to 0 on the next edge, and level and pulses SHALL be unchanged (glitch rejection).
REQ-009 When sync has differed for DEBOUNCE_CYCLES consecutive cycles, on that edge btn_level[i] SHALL take the sync value, the counter SHALL clear, and exactly one of btn_press[i] or btn_release[i] SHALL assert for one cycle.
REQ-010 Latency: a clean pin edge whose first sampled cycle is t SHALL change btn_level[i] and assert its pulse in cycle t+1+DEBOUNCE_CYCLES.
REQ-011 btn_press[i] and btn_release[i] SHALL never be high in the same cycle.
REQ-012 Channels SHALL be fully independent; simultaneous edges on several channels SHALL each produce their own pulses in the same cycle.
REQ-013 The counter SHALL never wrap; it saturates by the accept in REQ-009.

Reset
REQ-014 Asserting reset_n low SHALL, asynchronously, clear all synchronizer flops, counters, btn_level, btn_press, btn_release and repeat state to 0.
REQ-015 Reset mid-debounce or mid-pulse SHALL abandon the operation with no pulse emitted.
REQ-016 A button held high through reset release SHALL be debounced per REQ-010 from release and produce a single btn_press.

Configuration
REQ-017 With macro BTN_REPEAT_EN defined, each channel SHALL contain a repeat counter that is active only while btn_level[i]=1.
REQ-018 With BTN_REPEAT_EN, the repeat counter SHALL emit extra btn_press[i] pulses REPEAT_DELAY cycles after the accepted press, then every REPEAT_PERIOD cycles.
REQ-019 With BTN_REPEAT_EN, the repeat counter SHALL clear on the accepted release or on reset.
REQ-020 Without BTN_REPEAT_EN, no repeat logic SHALL be synthesized, and btn_press SHALL pulse exactly once per accepted press.

Structure
REQ-021 Package btn_pkg SHALL hold the default constants (DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD) and a typedef for the per-channel counter width function.
REQ-022 One sub-module, btn_debounce_channel, SHALL implement a single channel (synchronizer, stability counter, optional repeat).
REQ-023 button_conditioner SHALL generate NUM_BTN instances of btn_debounce_channel.

Verification
All scenarios use DEBOUNCE_CYCLES=8, REPEAT_DELAY=20, REPEAT_PERIOD=5.
REQ-024 Scenario 1 (clean press): btn_in[0] 0->1 and held 30 cycles -> btn_level[0]=1 and a single btn_press[0] pulse 10 cycles after the edge, with no btn_release.
REQ-025 Scenario 2 (bounce): btn_in[1] toggles every 3 cycles for 40 cycles, then stays 0 -> btn_level[1] stays 0 and no pulses occur.
REQ-026 Scenario 3 (release and simultaneity): btn_in[2] and btn_in[3] fall together after an accepted press -> btn_release[2] and btn_release[3] are high in the same cycle, 10 cycles after the edge.
REQ-027 Scenario 4 (reset): reset_n pulsed low at count 5 of a press -> all outputs 0 immediately and no pulse; with the pin still high after release, one press pulse follows 10 cycles later.
REQ-028 Scenario 5 (BTN_REPEAT_EN): btn_in[0] held 45 cycles past the accept -> press pulses at +0, +20, +25, +30, +35, +40.
REQ-029 Scenario 6 (no BTN_REPEAT_EN): the same stimulus as Scenario 5 -> a single press pulse.
